// File: rtl/pipeline_stall_ctrl.sv
// pipeline_stall_ctrl: turns hazard, branch and SRAM-wait signals into freeze/flush/bubble controls with watchdog and perf counters.
module pipeline_stall_ctrl #(
  parameter int MEM_TIMEOUT = 64,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             hazard_detected,
  input  logic             branch_taken,
  input  logic             mem_req,
  input  logic             mem_ready,
  output logic             freeze_all,
  output logic             pc_freeze,
  output logic             if_id_freeze,
  output logic             if_id_flush,
  output logic             id_ex_bubble,
  output logic             mem_timeout_err,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt,
  output logic [CNT_W-1:0] mem_wait_cnt
);
  typedef enum logic [1:0] {RUN, MEM_WAIT, ERR} state_t;
  localparam int WW = $clog2(MEM_TIMEOUT) + 1;
  localparam logic [CNT_W-1:0] CMAX = '1;
  state_t state, state_nx;
  logic [WW-1:0] wait_ctr;
  logic mem_wait, do_stall, do_flush, live;
  always_comb begin
    mem_wait = mem_req & ~mem_ready;
    live = (state != ERR);
    do_flush = live & ~mem_wait & branch_taken;
    do_stall = live & ~mem_wait & ~branch_taken & hazard_detected;
    freeze_all = ~live | mem_wait;
    pc_freeze = freeze_all | do_stall;
    if_id_freeze = pc_freeze;
    if_id_flush = do_flush;
    id_ex_bubble = do_flush | do_stall;
    mem_timeout_err = ~live;
    state_nx = ~live ? ERR :
               ~mem_wait ? RUN :
               (state == MEM_WAIT && wait_ctr == WW'(MEM_TIMEOUT - 1)) ? ERR : MEM_WAIT;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= RUN;
      wait_ctr <= '0;
      stall_cnt <= '0;
      flush_cnt <= '0;
      mem_wait_cnt <= '0;
    end else begin
      state <= state_nx;
      // the cycle that enters MEM_WAIT is already wait cycle 1
      if (live && mem_wait) wait_ctr <= (state == RUN) ? WW'(1) : wait_ctr + WW'(1);
      if (do_stall && stall_cnt != CMAX) stall_cnt <= stall_cnt + CNT_W'(1);
      if (do_flush && flush_cnt != CMAX) flush_cnt <= flush_cnt + CNT_W'(1);
      if (live && mem_wait && mem_wait_cnt != CMAX) mem_wait_cnt <= mem_wait_cnt + CNT_W'(1);
    end
  end
endmodule

// File: tb/tb_pipeline_stall_ctrl.sv
// tb_pipeline_stall_ctrl: directed and random stimulus against a run-length reference model of the stall controller.
module tb_pipeline_stall_ctrl;
  localparam int MT = 8;
  localparam int CW = 4;
  localparam int MAXC = 15;
  logic clk = 0, rst = 1, h = 0, b = 0, r = 0, y = 0;
  logic freeze_all, pc_freeze, if_id_freeze, if_id_flush, id_ex_bubble, mem_timeout_err;
  logic [CW-1:0] stall_cnt, flush_cnt, mem_wait_cnt;
  int checks = 0, failures = 0;
  bit m_err;
  int m_run, m_stall, m_flush, m_mw;
  logic [4:0] exp_ctl;
  logic [12:0] exp_cnt;
  wire [4:0] ctl = {freeze_all, pc_freeze, if_id_freeze, if_id_flush, id_ex_bubble};
  wire [12:0] cnt = {mem_timeout_err, stall_cnt, flush_cnt, mem_wait_cnt};

  pipeline_stall_ctrl #(.MEM_TIMEOUT(MT), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .hazard_detected(h), .branch_taken(b),
    .mem_req(r), .mem_ready(y), .freeze_all(freeze_all), .pc_freeze(pc_freeze),
    .if_id_freeze(if_id_freeze), .if_id_flush(if_id_flush), .id_ex_bubble(id_ex_bubble),
    .mem_timeout_err(mem_timeout_err), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt),
    .mem_wait_cnt(mem_wait_cnt)
  );

  always #5 clk = ~clk;

  function automatic int sat(input int v);
    return (v + 1 > MAXC) ? MAXC : v + 1;
  endfunction

  // controls: {freeze_all, pc_freeze, if_id_freeze, if_id_flush, id_ex_bubble}
  task automatic drive(input logic rs, input logic hh, input logic bb, input logic rr, input logic yy);
    rst = rs; h = hh; b = bb; r = rr; y = yy;
    #1;
    exp_ctl = (m_err || (rr && !yy)) ? 5'b11100 : bb ? 5'b00011 : hh ? 5'b01101 : 5'b00000;
    exp_cnt = {m_err, 4'(m_stall), 4'(m_flush), 4'(m_mw)};
  endtask

  task automatic tick();
    @(posedge clk);
    if (rst) begin
      m_err = 0; m_run = 0; m_stall = 0; m_flush = 0; m_mw = 0;
    end else if (!m_err) begin
      if (r && !y) begin
        m_mw = sat(m_mw);
        m_run++;
        if (m_run == MT) m_err = 1;
      end else begin
        m_run = 0;
        if (b) m_flush = sat(m_flush);
        else if (h) m_stall = sat(m_stall);
      end
    end
    @(negedge clk);
  endtask

  task automatic do_reset();
    drive(1, 0, 0, 0, 0);
    tick();
  endtask

  task automatic test_reset();
    drive(1, 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
    tick();
    drive(0, 0, 0, 0, 0);
    checks++;
    if (ctl !== 5'b00000) begin failures++; $display("FAIL reset_ctl got=%b exp=%b", ctl, 5'b00000); end
    checks++;
    if (cnt !== 13'd0) begin failures++; $display("FAIL reset_cnt got=%h exp=%h", cnt, 13'd0); end
    tick();
  endtask

  task automatic test_hazard();
    do_reset();
    for (int i = 0; i < 3; i++) begin
      drive(0, 1, 0, 0, 0);
      checks++;
      if (ctl !== exp_ctl) begin failures++; $display("FAIL hazard_ctl cyc=%0d got=%b exp=%b", i, ctl, exp_ctl); end
      tick();
    end
    drive(0, 0, 0, 0, 0);
    checks++;
    if (ctl !== exp_ctl) begin failures++; $display("FAIL hazard_idle got=%b exp=%b", ctl, exp_ctl); end
    checks++;
    if (cnt !== exp_cnt || stall_cnt !== 4'd3) begin failures++; $display("FAIL hazard_cnt got=%h exp=%h", cnt, exp_cnt); end
    tick();
  endtask

  task automatic test_branch_hazard();
    do_reset();
    drive(0, 1, 1, 0, 0);
    checks++;
    if (ctl !== exp_ctl || pc_freeze !== 1'b0) begin failures++; $display("FAIL branch_ctl got=%b exp=%b", ctl, exp_ctl); end
    tick();
    drive(0, 0, 0, 0, 0);
    checks++;
    if (cnt !== exp_cnt || flush_cnt !== 4'd1 || stall_cnt !== 4'd0) begin failures++; $display("FAIL branch_cnt got=%h exp=%h", cnt, exp_cnt); end
    tick();
  endtask

  task automatic test_mem_wait();
    do_reset();
    for (int i = 0; i < 6; i++) begin
      drive(0, 1, 0, i < 5, i >= 4);
      checks++;
      if (ctl !== exp_ctl) begin failures++; $display("FAIL memwait_ctl cyc=%0d got=%b exp=%b", i, ctl, exp_ctl); end
      tick();
    end
    drive(0, 0, 0, 0, 0);
    checks++;
    if (cnt !== exp_cnt || mem_wait_cnt !== 4'd4 || stall_cnt !== 4'd2) begin failures++; $display("FAIL memwait_cnt got=%h exp=%h", cnt, exp_cnt); end
    tick();
  endtask

  task automatic test_timeout();
    do_reset();
    for (int i = 0; i < 14; i++) begin
      drive(0, 1'($urandom), 1'($urandom), 1, i >= 10);
      checks++;
      if (ctl !== exp_ctl || cnt !== exp_cnt) begin
        failures++; $display("FAIL timeout cyc=%0d ctl=%b/%b cnt=%h/%h", i, ctl, exp_ctl, cnt, exp_cnt);
      end
      tick();
    end
    checks++;
    if (mem_timeout_err !== 1'b1 || mem_wait_cnt !== 4'd8) begin
      failures++; $display("FAIL timeout_final err=%b mw=%0d exp err=1 mw=8", mem_timeout_err, mem_wait_cnt);
    end
    drive(1, 0, 0, 0, 0);
    tick();
    drive(0, 0, 0, 0, 0);
    checks++;
    if (ctl !== 5'b00000 || cnt !== 13'd0) begin failures++; $display("FAIL err_reset ctl=%b cnt=%h exp 0", ctl, cnt); end
    tick();
  endtask

  task automatic test_saturate();
    do_reset();
    for (int i = 0; i < 20; i++) begin
      drive(0, 1, 0, 0, 0);
      tick();
    end
    drive(0, 0, 0, 0, 0);
    checks++;
    if (cnt !== exp_cnt || stall_cnt !== 4'd15) begin failures++; $display("FAIL saturate got=%h exp=%h", cnt, exp_cnt); end
    tick();
  endtask

  task automatic test_reset_mid_wait();
    do_reset();
    for (int i = 0; i < 3; i++) begin
      drive(0, 0, 0, 1, 0);
      tick();
    end
    drive(1, 0, 0, 1, 0);
    tick();
    drive(0, 0, 0, 0, 0);
    checks++;
    if (ctl !== 5'b00000 || cnt !== 13'd0) begin failures++; $display("FAIL midwait_reset ctl=%b cnt=%h exp 0", ctl, cnt); end
    tick();
  endtask

  task automatic test_random();
    logic rs;
    for (int i = 0; i < 600; i++) begin
      rs = ($urandom_range(0, 59) == 0);
      drive(rs, 1'($urandom), 1'($urandom_range(0, 2) == 0), 1'($urandom), $urandom_range(0, 4) == 0);
      if (!rs) begin
        checks++;
        if (ctl !== exp_ctl) begin failures++; $display("FAIL rand_ctl cyc=%0d got=%b exp=%b", i, ctl, exp_ctl); end
      end
      checks++;
      if (cnt !== exp_cnt) begin failures++; $display("FAIL rand_cnt cyc=%0d got=%h exp=%h", i, cnt, exp_cnt); end
      tick();
    end
  endtask

  initial begin
    @(negedge clk);
    tick();
    test_reset();
    test_hazard();
    test_branch_hazard();
    test_mem_wait();
    test_timeout();
    test_saturate();
    test_reset_mid_wait();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/pipeline_stall_ctrl.md
Name: pipeline_stall_ctrl

Overview:
- Consumer side of the pipeline hazard signalling: takes the hazard-detected flag, the EX-stage branch-taken flag and the MEM-stage SRAM handshake.
- Converts them into the freeze, flush and bubble controls that the pipeline registers and PC obey.
- Tracks SRAM wait time with a watchdog and a sticky error.
- Keeps saturating performance counters for stalls, flushes and memory-wait cycles. Sits beside the hazard unit in the top-level core.

Parameters:
- MEM_TIMEOUT, 64, max consecutive MEM_WAIT cycles before entering ERR (must be >= 2).
- CNT_W, 16, width of each performance counter.

Ports:
- clk  input  1  core clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- hazard_detected  input  1  data hazard from the hazard unit (ID-stage source matches EXE/MEM dest).
- branch_taken  input  1  EX stage resolved a taken branch this cycle.
- mem_req  input  1  MEM stage holds a load/store needing SRAM.
- mem_ready  input  1  SRAM completes the request this cycle.
- freeze_all  output  1  hold PC and every pipeline register.
- pc_freeze  output  1  hold PC.
- if_id_freeze  output  1  hold the IF/ID register.
- if_id_flush  output  1  zero the IF/ID register.
- id_ex_bubble  output  1  load NOP into the ID/EX register.
- mem_timeout_err  output  1  sticky watchdog error.
- stall_cnt  output  CNT_W  hazard-stall cycles.
- flush_cnt  output  CNT_W  branch flushes.
- mem_wait_cnt  output  CNT_W  cycles spent frozen on SRAM.

Behaviour:
- FSM states are RUN, MEM_WAIT and ERR. Reset state is RUN; all counters are 0 and mem_timeout_err is 0.
- After reset, all outputs evaluate combinationally from state and inputs. With all inputs 0, every output is 0.
- Internal signal wait = mem_req & ~mem_ready.
- Control priority, highest first: rst, then ERR, then wait, then branch_taken, then hazard_detected.
  - ERR: freeze_all=1, pc_freeze=1, if_id_freeze=1; flush and bubble are 0.
  - wait (state RUN or MEM_WAIT): freeze_all=pc_freeze=if_id_freeze=1; if_id_flush=id_ex_bubble=0. The branch and hazard inputs are ignored; they stay asserted and are re-evaluated after release.
  - Else if branch_taken: if_id_flush=1 and id_ex_bubble=1; no freeze. A hazard in the same cycle is ignored because its instruction is being squashed.
  - Else if hazard_detected: pc_freeze=1, if_id_freeze=1, id_ex_bubble=1.
  - Else all controls are 0.
- Transitions:
  - RUN -> MEM_WAIT when wait.
  - MEM_WAIT -> RUN when ~wait.
  - MEM_WAIT -> ERR when wait and wait_ctr == MEM_TIMEOUT-1.
  - ERR is held until rst.
- wait_ctr (internal, width clog2(MEM_TIMEOUT)+1):
  - Cleared on RUN->MEM_WAIT entry, then increments each cycle in MEM_WAIT with wait held.
  - The first wait cycle counts as wait 1.
  - ERR is entered on the clock edge ending wait cycle MEM_TIMEOUT; mem_timeout_err is 1 from the next cycle.
- mem_ready asserted in the same cycle as mem_req gives no freeze and no state change (zero-wait SRAM).
- Counters update on the rising edge and saturate at 2^CNT_W-1 (no wrap). Increment conditions, evaluated in the current cycle:
  - stall_cnt when the hazard branch is selected.
  - flush_cnt when the branch-flush branch is selected.
  - mem_wait_cnt when wait and state != ERR.
- Counters freeze in ERR.
- rst in any state, including mid MEM_WAIT or ERR, returns to RUN and clears the counters, wait_ctr and mem_timeout_err on that edge.

Test Plan:
- Reset, then hazard_detected=1 for 3 cycles -> pc_freeze, if_id_freeze and id_ex_bubble =1 for exactly those 3 cycles; stall_cnt=3; no other controls asserted.
- branch_taken=1 and hazard_detected=1 in the same cycle -> if_id_flush=1, id_ex_bubble=1, pc_freeze=0; flush_cnt=1, stall_cnt=0.
- mem_req=1, mem_ready=0 for 4 cycles then mem_ready=1 -> freeze_all=1 for 4 cycles and 0 on the ready cycle; mem_wait_cnt=4; state back in RUN. A hazard held throughout is suppressed, then produces a stall the cycle after release.
- MEM_TIMEOUT=8, mem_req=1 with mem_ready never asserted -> ERR entered after 8 wait cycles; mem_timeout_err=1 from cycle 9 and stays 1 through later mem_ready=1; mem_wait_cnt=8.
- CNT_W=4, hazard held 20 cycles -> stall_cnt climbs to 15 and stays 15.
- rst pulsed in ERR and mid MEM_WAIT -> next cycle state RUN, mem_timeout_err=0, all counters 0, all controls 0 with inputs low.
